alu_exec: RTL
=============

# alu_exec

Execute-stage wrapper around the 64-bit ALU: accepts decoded RV64I integer ops through a valid/ready handshake, registers operands, translates the op code into ALU enable and carry lines, post-processes the result (compares, 32-bit word ops), and presents a registered result with a destination tag to writeback. It sits between decode/register-read and writeback. It is a two-stage, full-throughput pipeline with backpressure and flush.

## Interface
- TAG_W, 5, width of the pass-through destination tag
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all in-flight ops this cycle
- in_valid_i  in  1  upstream op valid
- in_ready_o  out  1  block can accept op this cycle
- op_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10–15 illegal
- word_i  in  1  32-bit (W) variant
- a_i  in  64  operand A (rs1)
- b_i  in  64  operand B (rs2 or immediate)
- tag_i  in  TAG_W  destination tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- result_o  out  64  result
- tag_o  out  TAG_W  tag of result
- cflag_o, vflag_o, zflag_o  out  1 each  carry, overflow, zero of the result
- err_o  out  1  op was illegal

## Operation
- Stage S1: operand register (a, b, op, word, tag, s1_valid). Stage S2: result register (result, flags, err, tag, s2_valid = out_valid_o). ALU is combinational between S1 and S2.
- ALU drive from S1: ADD sum_en; SUB/SLT/SLTU sum_en, invB_en, cflag=1; XOR xor_en; AND and_en; OR and_en+xor_en (outputs OR-merged, giving A|B); SLL lsh_en; SRL rsh_en, cflag=0; SRA rsh_en, cflag=1; illegal: all enables 0.
- Shift amount: B[5:0] for 64-bit; for word_i, B bit 5 forced 0 (B[4:0] only).
- Word operand prep on A: SRL-W uses {32'd0, A[31:0]}; SRA-W uses {32{A[31]}, A[31:0]}; others unmodified.
- Word result: final result = {32{r[31]}, r[31:0]}. word_i with op not in {ADD, SUB, SLL, SRL, SRA}: op executes at 64 bits, then same sign-extension applies.
- SLT: result = {63'd0, out[63] ^ vflag}. SLTU: result = {63'd0, ~cflag} (borrow).
- Flags: cflag_o/vflag_o are raw ALU flags for the executed op (0 for non-sum ops); zflag_o = (final result == 0).
- Illegal op: result 0, zflag_o 1, cflag_o/vflag_o 0, err_o 1; still flows through handshake and tag is passed.

## Timing
- Reset: s1_valid=0, s2_valid=0; out_valid_o, result_o, tag_o, all flags, and err_o are 0. in_ready_o is 1 in the cycle after reset deasserts.
- s2_load = s1_valid & (~s2_valid | out_ready_i).
- in_ready_o = ~flush_i & (~s1_valid | s2_load); combinational path from out_ready_i.
- Input is accepted on an edge where in_valid_i & in_ready_o.
- Latency: op accepted at edge N is captured in S1 at N, in S2 at N+1, so out_valid_o is high after N+1. Sustains 1 op/cycle when out_ready_i is held 1.
- While out_valid_o & ~out_ready_i, S2 holds result_o, tag_o, flags, and err_o stable. With S1 also full, in_ready_o = 0.
- Simultaneous S2 drain and S1 refill in the same cycle must not drop or duplicate an op.
- flush_i: at the edge, s1_valid and s2_valid clear; an op presented that cycle is not accepted. flush_i overrides a concurrent out_ready_i handshake: that result is not delivered.
- Reset mid-operation: identical to flush, plus data registers go to 0.

## Test plan
- ADDW, a=0x7FFF_FFFF, b=1: result 0xFFFF_FFFF_8000_0000, vflag_o 0, out_valid_o 2 edges after accept.
- SRAW, a=0x8000_0000, b=4: result 0xFFFF_FFFF_F800_0000. SRA (64-bit), a=0x8000_0000_0000_0000, b=68: result 0xF800_0000_0000_0000 (amount 4).
- SLT/SLTU, a=0xFFFF_FFFF_FFFF_FFFF, b=1: SLT gives 1, SLTU gives 0. OR, a=0xF0, b=0x0F: 0xFF, zflag_o 0. SUB, a=b=5: 0, zflag_o 1.
- SLL, a=1, b=65: result 2. SLLW, a=1, b=33: result 2. op=12: result 0, err_o 1, tag_o = tag_i.
- Backpressure: stream 8 ops with out_ready_i held 0 for 5 cycles. in_ready_o falls after 2 accepts; all 8 results emerge in order with correct tags and none lost.
- flush_i while both stages are full and in_valid_i=1: next cycle out_valid_o=0, the flushed ops never appear, and the presented op is not accepted.

Source files
------------

// File: rtl/alu_exec.sv
// Execute stage for RV64I integer ops: operand register, combinational 64-bit ALU
// with word-op pre/post processing, and a result register toward writeback.
module alu_exec #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic             word_i,
  input  logic [63:0]      a_i,
  input  logic [63:0]      b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [63:0]      result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             cflag_o,
  output logic             vflag_o,
  output logic             zflag_o,
  output logic             err_o
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } op_e;

  logic             s1_valid;
  logic [63:0]      s1_a;
  logic [63:0]      s1_b;
  logic [3:0]       s1_op;
  logic             s1_word;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [63:0]      s2_result;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_c;
  logic             s2_v;
  logic             s2_z;
  logic             s2_err;

  logic s2_load;
  logic accept;

  assign s2_load    = s1_valid & (~s2_valid | out_ready_i);
  assign in_ready_o = ~flush_i & (~s1_valid | s2_load);
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_word  <= 1'b0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= ~flush_i & (accept | (s1_valid & ~s2_load));
      if (accept) begin
        s1_a    <= a_i;
        s1_b    <= b_i;
        s1_op   <= op_i;
        s1_word <= word_i;
        s1_tag  <= tag_i;
      end
    end
  end

  // ALU control decode
  logic sum_en, invb_en, cin, xor_en, and_en, lsh_en, rsh_en, legal;

  always_comb begin
    sum_en  = 1'b0;
    invb_en = 1'b0;
    cin     = 1'b0;
    xor_en  = 1'b0;
    and_en  = 1'b0;
    lsh_en  = 1'b0;
    rsh_en  = 1'b0;
    legal   = 1'b1;
    case (s1_op)
      OP_ADD:  sum_en = 1'b1;
      OP_SUB, OP_SLT, OP_SLTU: begin
        sum_en  = 1'b1;
        invb_en = 1'b1;
        cin     = 1'b1;
      end
      OP_XOR:  xor_en = 1'b1;
      OP_AND:  and_en = 1'b1;
      OP_OR: begin
        and_en = 1'b1;
        xor_en = 1'b1;
      end
      OP_SLL:  lsh_en = 1'b1;
      OP_SRL:  rsh_en = 1'b1;
      OP_SRA: begin
        rsh_en = 1'b1;
        cin    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  logic [5:0]  sh;
  logic [63:0] a_prep;
  logic [63:0] bx;
  logic [64:0] sum_full;
  logic [63:0] rsh;
  logic [63:0] alu_out;
  logic        alu_c;
  logic        alu_v;
  logic [63:0] res;

  always_comb begin
    sh = {s1_b[5] & ~s1_word, s1_b[4:0]};
    a_prep = s1_a;
    if (s1_word && s1_op == OP_SRL) a_prep = {32'd0, s1_a[31:0]};
    if (s1_word && s1_op == OP_SRA) a_prep = {{32{s1_a[31]}}, s1_a[31:0]};
    bx       = invb_en ? ~s1_b : s1_b;
    sum_full = {1'b0, a_prep} + {1'b0, bx} + {64'd0, cin};
    alu_c    = sum_en & sum_full[64];
    alu_v    = sum_en & (a_prep[63] == bx[63]) & (sum_full[63] != a_prep[63]);
    // Arithmetic right shift of a negative value done as ~(~a >> sh).
    rsh = (cin & a_prep[63]) ? ~(~a_prep >> sh) : (a_prep >> sh);
    alu_out = (sum_en ? sum_full[63:0]  : 64'd0)
            | (xor_en ? (a_prep ^ s1_b) : 64'd0)
            | (and_en ? (a_prep & s1_b) : 64'd0)
            | (lsh_en ? (a_prep << sh)  : 64'd0)
            | (rsh_en ? rsh             : 64'd0);
    case (s1_op)
      OP_SLT:  res = {63'd0, alu_out[63] ^ alu_v};
      OP_SLTU: res = {63'd0, ~alu_c};
      default: res = alu_out;
    endcase
    if (s1_word) res = {{32{res[31]}}, res[31:0]};
    if (!legal)  res = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
      s2_c      <= 1'b0;
      s2_v      <= 1'b0;
      s2_z      <= 1'b0;
      s2_err    <= 1'b0;
    end else begin
      s2_valid <= ~flush_i & (s2_load | (s2_valid & ~out_ready_i));
      if (s2_load && !flush_i) begin
        s2_result <= res;
        s2_tag    <= s1_tag;
        s2_c      <= alu_c;
        s2_v      <= alu_v;
        s2_z      <= (res == 64'd0);
        s2_err    <= ~legal;
      end
    end
  end

  assign out_valid_o = s2_valid;
  assign result_o    = s2_result;
  assign tag_o       = s2_tag;
  assign cflag_o     = s2_c;
  assign vflag_o     = s2_v;
  assign zflag_o     = s2_z;
  assign err_o       = s2_err;

endmodule
